// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with load, cascade tc and wrap/saturate terminal behaviour
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  wrapped
);
  logic [4*DIGITS-1:0] cnt_q, cnt_d, step, clamp;
  logic [DIGITS:0] chain;
  logic wrapped_q, wrapped_d;
  assign chain[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] n, l;
    assign n = cnt_q[4*d +: 4];
    assign l = load_val[4*d +: 4];
    assign chain[d+1] = chain[d] & (up ? n == 4'd9 : n == 4'd0);
    assign step[4*d +: 4] = !chain[d] ? n : up ? (n == 4'd9 ? 4'd0 : n + 4'd1) : (n == 4'd0 ? 4'd9 : n - 4'd1);
    assign clamp[4*d +: 4] = l > 4'd9 ? 4'd9 : l;
  end
  // chain[DIGITS] marks the terminal value for the current direction
  always_comb begin
    cnt_d = load ? clamp : (en && (WRAP || !chain[DIGITS])) ? step : cnt_q;
    wrapped_d = !load && en && chain[DIGITS] && WRAP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrapped_q <= wrapped_d;
    end
  end
  assign cnt = cnt_q;
  assign wrapped = wrapped_q;
  assign tc = en & chain[DIGITS];
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: randomized and directed check of wrap, saturate and cascaded instances against an integer model
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] cnt_w, cnt_s;
  logic tc_w, tc_s, wr_w, wr_s;
  logic [3:0] cnt_lo, cnt_hi;
  logic tc_lo, tc_hi, wr_lo, wr_hi;
  int tests = 0, fails = 0;
  int vw = 0, vs = 0;
  bit mw = 1'b0, ms = 1'b0, valid = 1'b0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt_w), .tc(tc_w), .wrapped(wr_w));
  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .cnt(cnt_s), .tc(tc_s), .wrapped(wr_s));
  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .cnt(cnt_lo), .tc(tc_lo), .wrapped(wr_lo));
  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (.clk(clk), .rst(rst), .en(tc_lo), .up(up), .load(load),
    .load_val(load_val[7:4]), .cnt(cnt_hi), .tc(tc_hi), .wrapped(wr_hi));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(input logic [7:0] lv);
    int h, l;
    h = lv[7:4] > 9 ? 9 : int'(lv[7:4]);
    l = lv[3:0] > 9 ? 9 : int'(lv[3:0]);
    return h * 10 + l;
  endfunction

  function automatic int nxt(input int v, input bit wrap, output bit w);
    w = 1'b0;
    if (rst) return 0;
    if (load) return clampv(load_val);
    if (!en) return v;
    if (up ? v == 99 : v == 0) begin
      if (!wrap) return v;
      w = 1'b1;
      return up ? 0 : 99;
    end
    return up ? v + 1 : v - 1;
  endfunction

  always @(posedge clk) begin
    if (rst) valid = 1'b1;
    vw = nxt(vw, 1'b1, mw);
    vs = nxt(vs, 1'b0, ms);
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("cnt_wrap", cnt_w, to_bcd(vw));
      chk("wrapped_wrap", wr_w, mw);
      chk("tc_wrap", tc_w, en && (up ? vw == 99 : vw == 0));
      chk("cnt_sat", cnt_s, to_bcd(vs));
      chk("wrapped_sat", wr_s, ms);
      chk("tc_sat", tc_s, en && (up ? vs == 99 : vs == 0));
      chk("cnt_cascade", {cnt_hi, cnt_lo}, to_bcd(vw));
    end
  end

  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 8'h00);
    chk("reset_cnt", cnt_w, 8'h00);
    chk("reset_wrapped", wr_w, 1'b0);
    en = 1; up = 0; #1;
    chk("reset_tc_down", tc_w, 1'b1);
    for (int i = 0; i < 99; i++) cyc(0, 1, 1, 0, 8'h00);
    chk("up_at_99", cnt_w, 8'h99);
    chk("tc_at_99", tc_w, 1'b1);
    cyc(0, 1, 1, 0, 8'h00);
    chk("up_wrap_00", cnt_w, 8'h00);
    chk("up_wrap_pulse", wr_w, 1'b1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("wrap_pulse_ends", wr_w, 1'b0);
    cyc(0, 0, 1, 1, 8'hA7);
    chk("load_A7", cnt_w, 8'h97);
    cyc(0, 1, 1, 1, 8'h3F);
    chk("load_3F_en", cnt_w, 8'h39);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    chk("down_00_to_99", cnt_w, 8'h99);
    chk("down_wrap_pulse", wr_w, 1'b1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("down_to_90", cnt_w, 8'h90);
    cyc(0, 1, 0, 0, 8'h00);
    chk("borrow_89", cnt_w, 8'h89);
    for (int i = 0; i < 89; i++) cyc(0, 1, 0, 0, 8'h00);
    chk("down_to_00", cnt_w, 8'h00);
    cyc(0, 0, 1, 1, 8'h98);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 8'h00);
    chk("sat_hold_99", cnt_s, 8'h99);
    chk("sat_no_wrap", wr_s, 1'b0);
    chk("wrap_inst_02", cnt_w, 8'h02);
    cyc(0, 1, 0, 0, 8'h00);
    chk("sat_down_98", cnt_s, 8'h98);
    cyc(0, 0, 0, 1, 8'h45);
    cyc(1, 1, 1, 1, 8'h77);
    chk("rst_wins", cnt_w, 8'h00);
    chk("rst_wrapped", wr_w, 1'b0);
    cyc(0, 0, 0, 1, 8'h50);
    cyc(0, 1, 1, 0, 8'h00);
    chk("toggle_51", cnt_w, 8'h51);
    cyc(0, 1, 0, 0, 8'h00);
    chk("toggle_50", cnt_w, 8'h50);
    cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    chk("toggle_50b", cnt_w, 8'h50);
    for (int i = 0; i < 250; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 9) == 0, 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
